serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- It is the inverse-direction counterpart to the combinational ripple-carry adder chain, and the team's area-cheap arithmetic unit for the Max1000 designs.
- Start/busy/done handshake; results are held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits (valid range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- diff  output  WIDTH  registered result, a - b mod 2^WIDTH.
- bout  output  1  final borrow; 1 when a < b unsigned.
- ovf  output  1  signed overflow of a - b (two's complement).
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - diff=0, bout=0, ovf=0, busy=0, done=0.
  - Shift registers, borrow and bit counter cleared.
  - Reset during RUN or DONE aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE; registered 2-bit encoding.
- IDLE:
  - If start=1 at an edge: load sa<=a, sb<=b, borrow<=0, cnt<=0, store a_msb=a[WIDTH-1] and b_msb=b[WIDTH-1], go to RUN.
  - Else remain in IDLE.
- RUN, each edge:
  - Full-subtractor cell: d = sa[0]^sb[0]^borrow; bnext = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Shift sa and sb right by 1.
  - Shift d into the MSB of the partial-result register.
  - borrow<=bnext; cnt<=cnt+1.
  - On the edge processing bit WIDTH-1 (cnt==WIDTH-1):
    - diff <= final partial result, including this bit.
    - bout <= bnext.
    - ovf <= (a_msb != b_msb) && (d != a_msb).
    - done<=1; go to DONE.
- DONE:
  - Next edge: done<=0, go to IDLE.
  - start is ignored in this state.
- Latency: done is high in the cycle after the WIDTH-th rising edge following the accepting edge. The operation occupies WIDTH+1 cycles, including the DONE cycle.
- Throughput: start held high continuously gives one result every WIDTH+2 cycles.
- Boundaries:
  - start during RUN or DONE: ignored; no queuing.
  - a and b may change freely after the accepting edge.
  - diff, bout and ovf change only on the completion edge. They hold their previous values throughout RUN.
  - cnt width is clog2(WIDTH)+1 bits; no wrap occurs inside one operation.
  - busy is combinational from state; done is registered.

Decomposition:
- Package serial_sub_pkg:
  - State localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Unused code 2'd3 recovers to IDLE on the next edge.
- One sub-module, fs: combinational full-subtractor bit cell.
  - Ports (d, bo, x, y, bi).
  - Structural: two half-subtractor stages plus an OR for the borrow.
  - Instantiated once in serial_sub.

Test Plan:
- Reset, then a=8'h05, b=8'h03, start for 1 cycle -> done pulses exactly 8 edges after accept; diff=8'h02, bout=0, ovf=0; busy high for 9 cycles.
- a=8'h03, b=8'h05 -> diff=8'hFE, bout=1, ovf=0.
- a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1. Then a=8'h7F, b=8'hFF -> diff=8'h80, bout=1, ovf=1.
- Accept a=8'hAA, b=8'h55; pulse start again and change a/b at the 3rd RUN cycle -> second start ignored; diff=8'h55 with no extra done. Previous diff stays constant until completion.
- Start with a=8'hFF, b=8'h00; drop rst_n at the 4th RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse. A new start then completes normally.
- start tied high, a=b=8'h00 -> back-to-back results every 10 cycles; diff=0, bout=0, ovf=0 each time.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_fs.sv
// fs: combinational full-subtractor built from two half-subtractor stages
module fs (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);
  logic d1, b1, b2;
  assign d1 = x ^ y;
  assign b1 = ~x & y;
  assign d  = d1 ^ bi;
  assign b2 = ~d1 & bi;
  assign bo = b1 | b2;
endmodule

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial subtractor with start/busy/done handshake
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [WIDTH-1:0] sa, sb, pr, res;
  logic [CW-1:0] cnt;
  logic borrow, a_msb, b_msb, d, bnext;
  fs u_fs (.d(d), .bo(bnext), .x(sa[0]), .y(sb[0]), .bi(borrow));
  assign res  = {d, pr[WIDTH-1:1]};
  assign busy = (state == S_RUN) || (state == S_DONE);
  // sequencer: load operands, shift one bit per edge, publish result on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      pr     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sa     <= a;
          sb     <= b;
          borrow <= 1'b0;
          cnt    <= '0;
          a_msb  <= a[WIDTH-1];
          b_msb  <= b[WIDTH-1];
          state  <= S_RUN;
        end
        S_RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          pr     <= res;
          borrow <= bnext;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= res;
            bout  <= bnext;
            ovf   <= (a_msb != b_msb) && (d != a_msb);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed scoreboard bench for serial_sub
module tb_serial_sub;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic bout, ovf, busy, done;
  int checks = 0, failures = 0;
  exp_t q[$];
  logic [W-1:0] last_diff = '0;
  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, x} - {1'b0, y};
    e.d = t[W-1:0];
    e.bo = t[W];
    e.ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_result(string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_diff"}, 32'(diff), 32'(e.d));
    chk({tag, "_bout"}, 32'(bout), 32'(e.bo));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
    last_diff = e.d;
  endtask
  task automatic op(string tag, logic [W-1:0] av, logic [W-1:0] bv, int pulse_n, logic [W-1:0] a2, logic [W-1:0] b2);
    int done_n, ndone, busy_n, hold_bad;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    q.push_back(model(av, bv));
    @(posedge clk);
    #1 start = 1'b0;
    done_n = 0;
    ndone = 0;
    busy_n = 0;
    hold_bad = 0;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge clk);
      if (n == pulse_n) begin
        start = 1'b1;
        a = a2;
        b = b2;
      end
      if (n == pulse_n + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        ndone++;
        if (done_n == 0) done_n = n;
      end
      if (n <= W && diff !== last_diff) hold_bad++;
    end
    chk({tag, "_done_cycle"}, done_n, W + 1);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_busy_cycles"}, busy_n, W + 1);
    chk({tag, "_hold"}, hold_bad, 0);
    check_result(tag);
  endtask
  initial begin
    int n_done, last_n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_flags", {bout, ovf, busy, done}, 0);
    rst_n = 1'b1;
    op("sub_5_3", 8'h05, 8'h03, 0, 8'h00, 8'h00);
    op("sub_3_5", 8'h03, 8'h05, 0, 8'h00, 8'h00);
    op("sub_80_01", 8'h80, 8'h01, 0, 8'h00, 8'h00);
    op("sub_7f_ff", 8'h7F, 8'hFF, 0, 8'h00, 8'h00);
    op("ignored_start", 8'hAA, 8'h55, 3, 8'h12, 8'h34);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_diff", 32'(diff), 0);
    chk("abort_flags", {bout, ovf, busy, done}, 0);
    rst_n = 1'b1;
    last_diff = '0;
    n_done = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    op("after_abort", 8'h12, 8'h34, 0, 8'h00, 8'h00);
    @(negedge clk);
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    repeat (3) q.push_back(model(8'h00, 8'h00));
    n_done = 0;
    last_n = 0;
    for (int n = 1; n <= 3 * (W + 2) + 6 && n_done < 3; n++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done > 1) chk("b2b_interval", n - last_n, W + 2);
        last_n = n;
        check_result("b2b");
        if (n_done == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", n_done, 3);
    repeat (W + 3) @(negedge clk);
    chk("final_idle", {busy, done}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
